// File: rtl/snake_trail.sv
`default_nettype none
// ============================================================================
// snake_trail : circular body-history buffer with serial self-collision scan
// Revision 1.0
// ============================================================================
module snake_trail #(
  parameter int MAX_LEN     = 64,
  parameter int SEG_SPACING = 12,
  parameter int INIT_LEN    = 4,
  parameter int GROW_STEP   = 2,
  parameter int SKIP        = 2,
  parameter int SEG_SIZE    = 12,
  localparam int AW         = $clog2(MAX_LEN)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          frame_tick,
  input  logic [9:0]    HeadX,
  input  logic [9:0]    HeadY,
  input  logic          grow,
  input  logic          clear,
  input  logic [AW-1:0] rd_idx,
  output logic [9:0]    rd_x,
  output logic [9:0]    rd_y,
  output logic          rd_valid,
  output logic [AW:0]   length,
  output logic          collide,
  output logic          scan_busy,
  output logic          scan_done
);

  localparam int LW = AW + 1;
  localparam int PW = AW + 2;
  localparam int CW = $clog2(SEG_SPACING + 1);
  localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);
  localparam logic [LW-1:0] SKIP_L    = LW'(SKIP);
  localparam logic [CW-1:0] SPACING_L = CW'(SEG_SPACING - 1);
  localparam logic [PW:0]   GROW_L    = (PW+1)'(GROW_STEP);
  localparam logic [10:0]   SIZE_L    = 11'(SEG_SIZE);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, PUSH = 2'd1, SCAN = 2'd2, DONE = 2'd3} state_t;
  state_t r_state, w_state_next;

  logic [19:0]   r_mem [MAX_LEN];
  logic [AW-1:0] r_wr_ptr;
  logic [LW-1:0] r_length;
  logic [PW-1:0] r_pending;
  logic [CW-1:0] r_frame_cnt;
  logic [9:0]    r_hx, r_hy;
  logic [LW-1:0] r_scan_k;
  logic          r_cmp_valid;
  logic [19:0]   r_scan_data;
  logic          r_collide;
  logic [19:0]   r_rd_data;
  logic          r_rd_valid;

  logic          w_len_inc;
  logic [LW-1:0] w_len_next;
  logic [PW-1:0] w_pend_dec, w_pend_next;
  logic [PW:0]   w_pend_sum;
  logic signed [10:0] w_dx, w_dy;
  logic [10:0]   w_adx, w_ady;
  logic          w_hit;

  assign w_len_inc  = (r_state == PUSH) && (r_pending != '0) && (r_length < MAX_LEN_L);
  assign w_len_next = r_length + LW'(w_len_inc);
  assign w_pend_dec = r_pending - PW'(w_len_inc);
  assign w_pend_sum = {1'b0, w_pend_dec} + GROW_L;
  // Grow saturates instead of wrapping so a burst of food is never lost
  assign w_pend_next = !grow ? w_pend_dec : (w_pend_sum[PW] ? '1 : w_pend_sum[PW-1:0]);

  assign w_dx  = $signed({1'b0, r_hx}) - $signed({1'b0, r_scan_data[19:10]});
  assign w_dy  = $signed({1'b0, r_hy}) - $signed({1'b0, r_scan_data[9:0]});
  assign w_adx = w_dx[10] ? 11'(-w_dx) : 11'(w_dx);
  assign w_ady = w_dy[10] ? 11'(-w_dy) : 11'(w_dy);
  assign w_hit = (w_adx < SIZE_L) && (w_ady < SIZE_L);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (frame_tick) begin
        if (r_frame_cnt == SPACING_L) w_state_next = PUSH;
        else                          w_state_next = (r_length > SKIP_L) ? SCAN : DONE;
      end
      PUSH:    w_state_next = (w_len_next > SKIP_L) ? SCAN : DONE;
      SCAN:    if (r_scan_k >= r_length) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (clear) w_state_next = IDLE;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wr_ptr    <= '0;
      r_length    <= '0;
      r_pending   <= PW'(INIT_LEN);
      r_frame_cnt <= SPACING_L;
      r_hx        <= '0;
      r_hy        <= '0;
      r_scan_k    <= SKIP_L;
      r_cmp_valid <= 1'b0;
      r_collide   <= 1'b0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
    end else if (clear) begin
      r_wr_ptr    <= '0;
      r_length    <= '0;
      r_pending   <= PW'(INIT_LEN);
      r_frame_cnt <= SPACING_L;
      r_hx        <= '0;
      r_hy        <= '0;
      r_scan_k    <= SKIP_L;
      r_cmp_valid <= 1'b0;
      r_collide   <= 1'b0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_rd_data  <= r_mem[r_wr_ptr - rd_idx];
      r_rd_valid <= {1'b0, rd_idx} < r_length;
      r_length   <= w_len_next;
      r_pending  <= w_pend_next;
      if (r_state == IDLE && frame_tick) begin
        r_hx        <= HeadX;
        r_hy        <= HeadY;
        r_frame_cnt <= (r_frame_cnt == SPACING_L) ? '0 : r_frame_cnt + CW'(1);
      end
      if (r_state == PUSH) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      // Read issue and compare are one stage apart; the final SCAN cycle only drains
      if (r_state == SCAN && r_scan_k < r_length) begin
        r_scan_k    <= r_scan_k + LW'(1);
        r_cmp_valid <= 1'b1;
      end else begin
        r_cmp_valid <= 1'b0;
        if (r_state != SCAN) r_scan_k <= SKIP_L;
      end
      if (r_cmp_valid && w_hit) r_collide <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (r_state == PUSH && !clear) r_mem[r_wr_ptr + PTR_ONE] <= {r_hx, r_hy};
    r_scan_data <= r_mem[r_wr_ptr - r_scan_k[AW-1:0]];
  end

  assign rd_x      = r_rd_data[19:10];
  assign rd_y      = r_rd_data[9:0];
  assign rd_valid  = r_rd_valid;
  assign length    = r_length;
  assign collide   = r_collide;
  assign scan_busy = (r_state != IDLE);
  assign scan_done = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_snake_trail.sv
`default_nettype none
// ============================================================================
// tb_snake_trail : directed self-checking bench for snake_trail
// Revision 1.0
// ============================================================================
module tb_snake_trail;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a, rst_n_b, tick_a, tick_b, grow_a, grow_b, clear_a, clear_b;
  logic [9:0] hx, hy;
  logic [5:0] idx_a;
  logic [2:0] idx_b;
  logic [9:0] rdx_a, rdy_a, rdx_b, rdy_b;
  logic       v_a, v_b, col_a, col_b, busy_a, busy_b, done_a, done_b;
  logic [6:0] len_a;
  logic [3:0] len_b;
  logic       sel;
  logic       done_s;
  int asserts = 0;
  int fails   = 0;

  assign done_s = sel ? done_b : done_a;

  snake_trail dut_a (
    .Clk(clk), .Reset_n(rst_n_a), .frame_tick(tick_a), .HeadX(hx), .HeadY(hy),
    .grow(grow_a), .clear(clear_a), .rd_idx(idx_a), .rd_x(rdx_a), .rd_y(rdy_a),
    .rd_valid(v_a), .length(len_a), .collide(col_a), .scan_busy(busy_a), .scan_done(done_a)
  );

  snake_trail #(.MAX_LEN(8), .SEG_SPACING(1), .INIT_LEN(10)) dut_b (
    .Clk(clk), .Reset_n(rst_n_b), .frame_tick(tick_b), .HeadX(hx), .HeadY(hy),
    .grow(grow_b), .clear(clear_b), .rd_idx(idx_b), .rd_x(rdx_b), .rd_y(rdy_b),
    .rd_valid(v_b), .length(len_b), .collide(col_b), .scan_busy(busy_b), .scan_done(done_b)
  );

  // Returns in the scan_done cycle; cyc is that cycle's offset from the tick (or -1)
  task automatic do_frame(input logic s, input logic [9:0] x, input logic [9:0] y,
                          input logic gp, output int cyc);
    int c;
    sel = s;
    @(negedge clk);
    hx = x; hy = y;
    if (s) tick_b = 1'b1; else tick_a = 1'b1;
    @(negedge clk);
    tick_a = 1'b0; tick_b = 1'b0; grow_a = gp; c = 1;
    while (done_s !== 1'b1 && c < 100) begin
      @(negedge clk);
      grow_a = 1'b0;
      c++;
    end
    grow_a = 1'b0;
    cyc = (done_s === 1'b1) ? c : -1;
  endtask

  task automatic do_read(input logic s, input int idx, output logic [9:0] x,
                         output logic [9:0] y, output logic v);
    @(negedge clk);
    if (s) idx_b = 3'(idx); else idx_a = 6'(idx);
    @(negedge clk);
    x = s ? rdx_b : rdx_a;
    y = s ? rdy_b : rdy_a;
    v = s ? v_b : v_a;
  endtask

  task automatic pulse_grow();
    @(negedge clk); grow_a = 1'b1;
    @(negedge clk); grow_a = 1'b0;
  endtask

  task automatic test_reset();
    asserts++; if (len_a !== 7'd0) begin fails++; $display("FAIL reset_length: got %0d expected 0", len_a); end
    asserts++; if ({rdx_a, rdy_a, v_a} !== 21'd0) begin fails++; $display("FAIL reset_read: got %0d/%0d/%0d expected 0", rdx_a, rdy_a, v_a); end
    asserts++; if ({col_a, busy_a, done_a} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b expected 000", {col_a, busy_a, done_a}); end
    asserts++; if (len_b !== 4'd0) begin fails++; $display("FAIL reset_length_b: got %0d expected 0", len_b); end
  endtask

  task automatic test_first_push();
    int c;
    logic [9:0] x, y;
    logic v;
    do_frame(1'b0, 10'd350, 10'd240, 1'b0, c);
    asserts++; if (c !== 2) begin fails++; $display("FAIL first_push_latency: got %0d expected 2", c); end
    asserts++; if (len_a !== 7'd1) begin fails++; $display("FAIL first_push_length: got %0d expected 1", len_a); end
    do_read(1'b0, 0, x, y, v);
    asserts++; if ({x, y, v} !== {10'd350, 10'd240, 1'b1}) begin fails++; $display("FAIL first_push_rd0: got %0d,%0d v=%0d expected 350,240 v=1", x, y, v); end
    do_read(1'b0, 1, x, y, v);
    asserts++; if (v !== 1'b0) begin fails++; $display("FAIL first_push_rd1_valid: got %0d expected 0", v); end
  endtask

  task automatic test_fill();
    int c, e;
    int exp_x[4] = '{386, 374, 362, 350};
    logic [9:0] x, y;
    logic v;
    for (int n = 1; n <= 36; n++) begin
      do_frame(1'b0, 10'(350 + n), 10'd240, 1'b0, c);
      asserts++; if (c < 0) begin fails++; $display("FAIL fill_scan_done n=%0d: got none expected pulse", n); end
      if (n == 1 || n == 12 || n == 24 || n == 25 || n == 36) begin
        e = (n == 1) ? 1 : (n == 12) ? 2 : (n == 24) ? 4 : (n == 25) ? 3 : 5;
        asserts++; if (c !== e) begin fails++; $display("FAIL fill_latency n=%0d: got %0d expected %0d", n, c, e); end
      end
    end
    asserts++; if (len_a !== 7'd4) begin fails++; $display("FAIL fill_length: got %0d expected 4", len_a); end
    asserts++; if (col_a !== 1'b0) begin fails++; $display("FAIL fill_collide: got %0d expected 0", col_a); end
    for (int k = 0; k < 4; k++) begin
      do_read(1'b0, k, x, y, v);
      asserts++; if ({x, v} !== {10'(exp_x[k]), 1'b1}) begin fails++; $display("FAIL fill_rd%0d: got x=%0d v=%0d expected x=%0d v=1", k, x, v, exp_x[k]); end
    end
  endtask

  task automatic test_pending_hold();
    int c;
    logic [9:0] x, y;
    logic v;
    for (int n = 37; n <= 48; n++) do_frame(1'b0, 10'(350 + n), 10'd240, 1'b0, c);
    asserts++; if (len_a !== 7'd4) begin fails++; $display("FAIL hold_length: got %0d expected 4", len_a); end
    do_read(1'b0, 0, x, y, v);
    asserts++; if (x !== 10'd398) begin fails++; $display("FAIL hold_rd0: got %0d expected 398", x); end
  endtask

  task automatic test_grow();
    int c;
    logic [9:0] x, y;
    logic v;
    pulse_grow();
    for (int n = 49; n <= 72; n++) do_frame(1'b0, 10'(350 + n), 10'd240, 1'b0, c);
    asserts++; if (len_a !== 7'd6) begin fails++; $display("FAIL grow_length: got %0d expected 6", len_a); end
    do_read(1'b0, 0, x, y, v);
    asserts++; if (x !== 10'd422) begin fails++; $display("FAIL grow_rd0: got %0d expected 422", x); end
  endtask

  task automatic test_grow_in_push();
    int c;
    pulse_grow();
    for (int n = 73; n <= 84; n++) do_frame(1'b0, 10'(350 + n), 10'd240, (n == 84), c);
    asserts++; if (len_a !== 7'd7) begin fails++; $display("FAIL grow_push_length: got %0d expected 7", len_a); end
    for (int n = 85; n <= 132; n++) do_frame(1'b0, 10'(350 + n), 10'd240, 1'b0, c);
    asserts++; if (len_a !== 7'd10) begin fails++; $display("FAIL grow_push_final_length: got %0d expected 10", len_a); end
  endtask

  task automatic test_collide();
    int c;
    do_frame(1'b0, 10'd475, 10'd240, 1'b0, c);
    asserts++; if (c !== 10) begin fails++; $display("FAIL scan_latency: got %0d expected 10", c); end
    asserts++; if (col_a !== 1'b0) begin fails++; $display("FAIL collide_skip: got %0d expected 0", col_a); end
    do_frame(1'b0, 10'd458, 10'd253, 1'b0, c);
    asserts++; if (col_a !== 1'b0) begin fails++; $display("FAIL collide_edge: got %0d expected 0", col_a); end
    do_frame(1'b0, 10'd458, 10'd251, 1'b0, c);
    asserts++; if ({col_a, done_a} !== 2'b11) begin fails++; $display("FAIL collide_hit: got col=%0d done=%0d expected 1,1", col_a, done_a); end
    do_frame(1'b0, 10'd100, 10'd100, 1'b0, c);
    asserts++; if (col_a !== 1'b1) begin fails++; $display("FAIL collide_sticky: got %0d expected 1", col_a); end
  endtask

  task automatic test_clear_mid_scan();
    int c;
    int spurious = 0;
    sel = 1'b0;
    @(negedge clk); hx = 10'd300; hy = 10'd300; tick_a = 1'b1;
    @(negedge clk); tick_a = 1'b0;
    asserts++; if (busy_a !== 1'b1) begin fails++; $display("FAIL clear_busy_before: got %0d expected 1", busy_a); end
    @(negedge clk);
    @(negedge clk); clear_a = 1'b1;
    @(negedge clk); clear_a = 1'b0;
    asserts++; if ({len_a, col_a, busy_a, done_a, v_a, rdx_a, rdy_a} !== 31'd0) begin fails++;
      $display("FAIL clear_outputs: got len=%0d col=%0d busy=%0d done=%0d v=%0d x=%0d y=%0d expected all 0", len_a, col_a, busy_a, done_a, v_a, rdx_a, rdy_a); end
    for (int i = 0; i < 15; i++) begin @(negedge clk); if (done_a === 1'b1) spurious++; end
    asserts++; if (spurious !== 0) begin fails++; $display("FAIL clear_no_done: got %0d pulses expected 0", spurious); end
    do_frame(1'b0, 10'd200, 10'd200, 1'b0, c);
    asserts++; if ({c == 2, len_a} !== {1'b1, 7'd1}) begin fails++; $display("FAIL clear_repush: got latency=%0d len=%0d expected 2,1", c, len_a); end
  endtask

  task automatic test_max_len_wrap();
    int c;
    logic [9:0] x, y;
    logic v;
    for (int n = 0; n <= 10; n++) do_frame(1'b1, 10'(100 + 20 * n), 10'd50, 1'b0, c);
    asserts++; if (c !== 9) begin fails++; $display("FAIL wrap_latency: got %0d expected 9", c); end
    asserts++; if (len_b !== 4'd8) begin fails++; $display("FAIL wrap_length: got %0d expected 8", len_b); end
    do_read(1'b1, 7, x, y, v);
    asserts++; if ({x, y, v} !== {10'd160, 10'd50, 1'b1}) begin fails++; $display("FAIL wrap_rd7: got %0d,%0d v=%0d expected 160,50 v=1", x, y, v); end
    do_read(1'b1, 0, x, y, v);
    asserts++; if (x !== 10'd300) begin fails++; $display("FAIL wrap_rd0: got %0d expected 300", x); end
  endtask

  task automatic test_async_reset();
    int c;
    int spurious = 0;
    sel = 1'b1;
    @(negedge clk); hx = 10'd320; hy = 10'd50; tick_b = 1'b1;
    @(negedge clk); tick_b = 1'b0;
    @(negedge clk);
    asserts++; if (busy_b !== 1'b1) begin fails++; $display("FAIL areset_busy_before: got %0d expected 1", busy_b); end
    rst_n_b = 1'b0;
    #1;
    asserts++; if ({len_b, col_b, busy_b, done_b, v_b, rdx_b, rdy_b} !== 28'd0) begin fails++;
      $display("FAIL areset_outputs: got len=%0d busy=%0d done=%0d v=%0d x=%0d expected all 0", len_b, busy_b, done_b, v_b, rdx_b); end
    @(negedge clk);
    @(negedge clk); rst_n_b = 1'b1;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (done_b === 1'b1) spurious++; end
    asserts++; if (spurious !== 0) begin fails++; $display("FAIL areset_no_done: got %0d pulses expected 0", spurious); end
    do_frame(1'b1, 10'd500, 10'd60, 1'b0, c);
    asserts++; if ({c == 2, len_b} !== {1'b1, 4'd1}) begin fails++; $display("FAIL areset_repush: got latency=%0d len=%0d expected 2,1", c, len_b); end
  endtask

  initial begin
    rst_n_a = 1'b0; rst_n_b = 1'b0; tick_a = 1'b0; tick_b = 1'b0;
    grow_a = 1'b0; grow_b = 1'b0; clear_a = 1'b0; clear_b = 1'b0;
    hx = '0; hy = '0; idx_a = '0; idx_b = '0; sel = 1'b0;
    repeat (3) @(negedge clk);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    @(negedge clk);
    test_reset();
    test_first_push();
    test_fill();
    test_pending_hold();
    test_grow();
    test_grow_in_push();
    test_collide();
    test_clear_mid_scan();
    test_max_len_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
`default_nettype wire
